tc_fastram_arbiter: RTL and testbench
=====================================

Name: tc_fastram_arbiter

Overview:
- Two-requester round-robin arbiter/sequencer in front of one TC_FastRam instance (the shared 4x64-bit-lane RAM).
- Accepts independent read/write commands over a req/ack handshake and serialises them onto the RAM's load/save/address/in lanes.
- Captures read data into a registered response.
- Checks address range and masks data to BIT_WIDTH so requesters never see stale upper lanes.

Parameters:
- UUID, 0, instance id (unused in logic)
- NAME, "", instance name (unused in logic)
- BIT_WIDTH, 16, RAM word width; must equal the attached RAM's BIT_WIDTH (16..256)
- BIT_DEPTH, 256, RAM depth; valid addresses 0..BIT_DEPTH-1

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  synchronous active-high reset
- r0_req  in  1  requester 0 command valid
- r0_we  in  1  1=write, 0=read
- r0_addr  in  16  word address
- r0_wdata  in  256  write data; lane k = bits [64k+63:64k]
- r0_ack  out  1  one-cycle completion pulse for requester 0
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack  same as requester 0
- rdata  out  256  read data, valid while either ack is high
- err  out  1  out-of-range flag, valid with ack
- ram_load  out  1  to RAM load
- ram_save  out  1  to RAM save
- ram_address  out  16  to RAM address
- ram_in0..ram_in3  out  64 each  to RAM in0..in3
- ram_out0..ram_out3  in  64 each  from RAM out0..out3 (combinational read)

Behaviour:
- Reset: rst is synchronous active-high on clk.
  - State=IDLE, r0_ack=r1_ack=0, rdata=0, err=0, last_grant=1 (requester 0 wins the first tie).
- Reset gating: ram_load and ram_save are combinationally forced to 0 while rst=1, so no RAM write occurs in a reset cycle even if the FSM is in ACCESS.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Fixed latency of 3 cycles per transaction.
- IDLE:
  - RAM outputs are idle: load=0, save=0, address=0, in*=0.
  - If any req is sampled high at posedge, pick the winner.
  - Only one req high: that requester wins.
  - Both high: the requester != last_grant wins.
  - Latch the winner's we/addr/wdata and id into command registers; update last_grant; go to ACCESS.
- ACCESS (one cycle):
  - ram_address = latched addr.
  - Write in range: ram_save=1 and ram_in lanes = latched wdata masked to BIT_WIDTH (lanes wholly above BIT_WIDTH driven 0). The RAM commits on this cycle's negedge.
  - Read in range: ram_load=1. At the posedge ending ACCESS, rdata <= {ram_out3..ram_out0} masked to BIT_WIDTH.
  - Write: rdata <= 0.
  - Out of range (addr >= BIT_DEPTH): save=load=0, rdata <= 0, err <= 1; otherwise err <= 0.
  - Next state RESP; the winner's ack register is set.
- RESP (one cycle):
  - Winner's ack=1 and the other ack=0; rdata/err hold.
  - req inputs are not sampled.
  - Next state IDLE: ack clears, rdata/err hold until the next ACCESS completes.
- Handshake:
  - A requester keeps req and its command stable from assertion until it sees ack.
  - A req still high in the IDLE cycle after ack is a new transaction.
  - The loser keeps waiting. With both requesters continuously requesting, grants strictly alternate, giving a worst-case wait of one transaction (3 cycles) before own grant.
- Reset mid-transaction: command discarded, no ack issued, no RAM write in the reset cycle. The requester must re-issue.
- Width rules: the address is compared full 16-bit against BIT_DEPTH. Masking uses the BIT_WIDTH low bits of the 256-bit vector; upper bits are 0.

Test Plan:
1. Reset, then r0 write addr 5 data 0x1234 (BIT_WIDTH=16) -> ram_save=1 exactly one cycle with ram_address=5, ram_in0=0x1234; r0_ack pulses 2 cycles after the req sample; err=0.
2. r1 read addr 5 after (1) -> ram_load=1 in ACCESS; r1_ack pulse with rdata=0x1234. Then write 0xABCDE at BIT_WIDTH=16 -> read returns 0xBCDE.
3. r0_req and r1_req both held high from reset for 4 transactions -> grant order r0, r1, r0, r1; acks never overlap; each ack 3 cycles apart.
4. r0 write addr 256 (BIT_DEPTH=256) -> ram_save never asserted, r0_ack with err=1. A following read of addr 255 -> err=0.
5. rst asserted during ACCESS of a write to addr 7 -> no save, no ack, outputs at reset values next cycle; a subsequent read of addr 7 returns 0.
6. BIT_WIDTH=256: write with four distinct 64-bit lanes -> ram_in0..3 match; read back returns the same 256-bit rdata.

Source files
------------

// File: rtl/tc_fastram_arbiter.sv
// Two-requester round-robin arbiter in front of one TC_FastRam instance.
// Each transaction runs IDLE -> ACCESS -> RESP (three cycles). The winner gets a
// one-cycle ack in RESP, together with registered read data and an out-of-range flag.
//
// Handshake: a requester raises req with we/addr/wdata and holds all of them stable
// until it sees its ack high. The ack is high for exactly one cycle. A req that is still
// high in the IDLE cycle after the ack is a new transaction. req is sampled only in IDLE.
module tc_fastram_arbiter #(
    parameter int UUID      = 0,
    parameter     NAME      = "",
    parameter int BIT_WIDTH = 16,
    parameter int BIT_DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_req,
    input  logic         r0_we,
    input  logic [15:0]  r0_addr,
    input  logic [255:0] r0_wdata,
    output logic         r0_ack,
    input  logic         r1_req,
    input  logic         r1_we,
    input  logic [15:0]  r1_addr,
    input  logic [255:0] r1_wdata,
    output logic         r1_ack,
    output logic [255:0] rdata,
    output logic         err,
    output logic         ram_load,
    output logic         ram_save,
    output logic [15:0]  ram_address,
    output logic [63:0]  ram_in0,
    output logic [63:0]  ram_in1,
    output logic [63:0]  ram_in2,
    output logic [63:0]  ram_in3,
    input  logic [63:0]  ram_out0,
    input  logic [63:0]  ram_out1,
    input  logic [63:0]  ram_out2,
    input  logic [63:0]  ram_out3,
    output logic [1:0]   fsm_state
);

    // The identity parameters are metadata only. They are named here so that they count as consumed.
    if (UUID < 0 || $bits(NAME) == 0) begin : g_identity_params
    end

    // Low BIT_WIDTH bits set. Lanes above the RAM word width always read and write as zero.
    localparam logic [255:0] DATA_MASK =
        (BIT_WIDTH >= 256) ? {256{1'b1}} : ((256'd1 << BIT_WIDTH) - 256'd1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         last_grant;
    logic         grant_id;
    logic         any_req;
    logic         cmd_id;
    logic         cmd_we;
    logic [15:0]  cmd_addr;
    logic [255:0] cmd_wdata;
    logic         in_range;
    logic [255:0] wr_lanes;
    logic [255:0] rd_lanes;

    assign any_req   = r0_req | r1_req;
    assign in_range  = (32'(cmd_addr) < 32'(BIT_DEPTH));
    assign rd_lanes  = {ram_out3, ram_out2, ram_out1, ram_out0} & DATA_MASK;
    assign fsm_state = state;

    // Winner selection: a lone requester wins. On a tie, the requester that did not win last time wins.
    always_comb begin
        grant_id = 1'b0;
        if (r0_req && r1_req) begin
            grant_id = ~last_grant;
        end else if (r1_req) begin
            grant_id = 1'b1;
        end
    end

    // Next-state logic. Only IDLE waits for a request. The other two states always advance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // RAM drive. The bus is quiet outside ACCESS. load and save are gated by rst so that a reset cycle never commits.
    always_comb begin
        ram_load    = 1'b0;
        ram_save    = 1'b0;
        ram_address = 16'd0;
        wr_lanes    = '0;
        if (state == ACCESS) begin
            ram_address = cmd_addr;
            if (in_range) begin
                if (cmd_we) begin
                    ram_save = ~rst;
                    wr_lanes = cmd_wdata & DATA_MASK;
                end else begin
                    ram_load = ~rst;
                end
            end
        end
    end

    assign ram_in0 = wr_lanes[63:0];
    assign ram_in1 = wr_lanes[127:64];
    assign ram_in2 = wr_lanes[191:128];
    assign ram_in3 = wr_lanes[255:192];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command capture from the winner when leaving IDLE. The command is only read in ACCESS, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && any_req) begin
            cmd_id    <= grant_id;
            cmd_we    <= grant_id ? r1_we    : r0_we;
            cmd_addr  <= grant_id ? r1_addr  : r0_addr;
            cmd_wdata <= grant_id ? r1_wdata : r0_wdata;
        end
    end

    // Response registers: the fairness pointer, the per-requester ack, read data and the range flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            r0_ack     <= 1'b0;
            r1_ack     <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) last_grant <= grant_id;
                end
                ACCESS: begin
                    r0_ack <= ~cmd_id;
                    r1_ack <= cmd_id;
                    if (!in_range) begin
                        rdata <= '0;
                        err   <= 1'b1;
                    end else begin
                        rdata <= cmd_we ? '0 : rd_lanes;
                        err   <= 1'b0;
                    end
                end
                RESP: begin
                    r0_ack <= 1'b0;
                    r1_ack <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_fastram_arbiter.sv
// Bench for tc_fastram_arbiter. Two instances (BIT_WIDTH 16 and 256) share one stimulus stream.
// Each instance has its own behavioural RAM. A transaction-level reference model predicts
// every output on every cycle.
module tb_tc_fastram_arbiter;

    localparam int DEPTH = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         nxt_rst;
    logic         r0_req, r0_we, r1_req, r1_we;
    logic [15:0]  r0_addr, r1_addr;
    logic [255:0] r0_wdata, r1_wdata;

    logic         r0_ack_o   [2];
    logic         r1_ack_o   [2];
    logic         err_o      [2];
    logic         ram_load_o [2];
    logic         ram_save_o [2];
    logic [255:0] rdata_o    [2];
    logic [15:0]  ram_addr_o [2];
    logic [1:0]   st_o       [2];
    logic [63:0]  ram_in_o   [2][4];
    logic [63:0]  ram_out_i  [2][4];
    logic [255:0] ram_mem    [2][DEPTH];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tc_fastram_arbiter #(
            .UUID(g), .NAME("arb"), .BIT_WIDTH(g == 0 ? 16 : 256), .BIT_DEPTH(DEPTH)
        ) dut (
            .clk(clk), .rst(rst),
            .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack_o[g]),
            .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack_o[g]),
            .rdata(rdata_o[g]), .err(err_o[g]),
            .ram_load(ram_load_o[g]), .ram_save(ram_save_o[g]), .ram_address(ram_addr_o[g]),
            .ram_in0(ram_in_o[g][0]), .ram_in1(ram_in_o[g][1]), .ram_in2(ram_in_o[g][2]), .ram_in3(ram_in_o[g][3]),
            .ram_out0(ram_out_i[g][0]), .ram_out1(ram_out_i[g][1]), .ram_out2(ram_out_i[g][2]), .ram_out3(ram_out_i[g][3]),
            .fsm_state(st_o[g])
        );
        for (genvar k = 0; k < 4; k++) begin : g_lane
            assign ram_out_i[g][k] = (ram_addr_o[g] < 16'(DEPTH)) ? ram_mem[g][ram_addr_o[g][7:0]][64*k +: 64] : 64'd0;
        end
    end

    // Behavioural TC_FastRam: the read is combinational and a save commits on the falling edge.
    initial begin
        for (int g = 0; g < 2; g++)
            for (int a = 0; a < DEPTH; a++) ram_mem[g][a] = '0;
    end
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++)
            if (ram_save_o[g] === 1'b1)
                ram_mem[g][ram_addr_o[g][7:0]] = {ram_in_o[g][3], ram_in_o[g][2], ram_in_o[g][1], ram_in_o[g][0]};
    end

    // ---------------- scoreboard ----------------
    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int sv_cnt [2] = '{0, 0};
    int ld_cnt [2] = '{0, 0};
    logic [15:0]  sv_addr [2];
    logic [255:0] sv_in   [2];
    int ack_overlap = 0;
    logic [255:0] exp_q[$];

    task automatic chk(input string name, input int g, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] t=%0t got=%h expected=%h", name, g, $time, act, exp);
    endtask

    function automatic logic [255:0] mask_of(input int g);
        logic [255:0] m;
        m = (g == 0) ? 256'(16'hFFFF) : {256{1'b1}};
        return m;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [15:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return 16'($urandom_range(250, 262));
        return 16'($urandom_range(0, 31));
    endfunction

    // ---------------- reference model ----------------
    // m_busy counts the cycles since a grant: 0 = free, 1 = RAM cycle, 2 = response cycle.
    int         m_busy = 0;
    bit         m_lg = 1'b1;
    bit         m_id, m_we, m_err;
    bit [15:0]  m_addr;
    bit [255:0] m_wdata;
    bit         m_ack   [2];
    bit [255:0] m_rdata [2];
    bit [255:0] m_mem   [2][DEPTH];

    task automatic model_step();
        if (rst) begin
            m_busy = 0; m_lg = 1'b1; m_ack[0] = 0; m_ack[1] = 0; m_err = 0;
            m_rdata[0] = '0; m_rdata[1] = '0;
        end else if (m_busy == 0) begin
            if (r0_req || r1_req) begin
                if (r0_req && r1_req) m_id = ~m_lg;
                else m_id = r1_req;
                m_lg    = m_id;
                m_we    = m_id ? r1_we : r0_we;
                m_addr  = m_id ? r1_addr : r0_addr;
                m_wdata = m_id ? r1_wdata : r0_wdata;
                m_busy  = 1;
            end
        end else if (m_busy == 1) begin
            for (int g = 0; g < 2; g++)
                m_rdata[g] = (m_addr >= DEPTH || m_we) ? '0 : m_mem[g][m_addr[7:0]];
            m_err = (m_addr >= DEPTH);
            m_ack[m_id] = 1'b1;
            m_busy = 2;
            exp_q.push_back(m_rdata[1]);
        end else begin
            m_ack[0] = 0; m_ack[1] = 0; m_busy = 0;
        end
    endtask

    task automatic check_cycle();
        for (int g = 0; g < 2; g++) begin
            bit acc;
            bit inr;
            bit e_save;
            logic [255:0] e_in;
            logic [255:0] a_in;
            acc    = (m_busy == 1);
            inr    = (m_addr < DEPTH);
            e_save = acc && !rst && m_we && inr;
            e_in   = (acc && m_we && inr) ? (m_wdata & mask_of(g)) : '0;
            a_in   = {ram_in_o[g][3], ram_in_o[g][2], ram_in_o[g][1], ram_in_o[g][0]};
            chk("r0_ack", g, 256'(r0_ack_o[g]), 256'(m_ack[0]));
            chk("r1_ack", g, 256'(r1_ack_o[g]), 256'(m_ack[1]));
            chk("rdata", g, rdata_o[g], m_rdata[g]);
            chk("err", g, 256'(err_o[g]), 256'(m_err));
            chk("ram_save", g, 256'(ram_save_o[g]), 256'(e_save));
            chk("ram_load", g, 256'(ram_load_o[g]), 256'(acc && !rst && !m_we && inr));
            chk("ram_address", g, 256'(ram_addr_o[g]), acc ? 256'(m_addr) : '0);
            chk("ram_in", g, a_in, e_in);
            if (e_save) m_mem[g][m_addr[7:0]] = e_in;
            if (ram_save_o[g] === 1'b1) begin
                sv_cnt[g]++; sv_addr[g] = ram_addr_o[g]; sv_in[g] = a_in;
            end
            if (ram_load_o[g] === 1'b1) ld_cnt[g]++;
        end
        if (r0_ack_o[0] === 1'b1 && r1_ack_o[0] === 1'b1) ack_overlap++;
        if (r0_ack_o[1] === 1'b1 || r1_ack_o[1] === 1'b1) begin
            if (exp_q.size() == 0) chk("resp_q_empty", 1, 256'd1, 256'd0);
            else chk("resp_q", 1, rdata_o[1], exp_q.pop_front());
        end
    endtask

    // ---------------- driver ----------------
    logic         rq_req   [2] = '{1'b0, 1'b0};
    logic         rq_we    [2] = '{1'b0, 1'b0};
    logic [15:0]  rq_addr  [2] = '{16'd0, 16'd0};
    logic [255:0] rq_wdata [2] = '{256'd0, 256'd0};

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        rst = nxt_rst;
        r0_req = rq_req[0]; r0_we = rq_we[0]; r0_addr = rq_addr[0]; r0_wdata = rq_wdata[0];
        r1_req = rq_req[1]; r1_we = rq_we[1]; r1_addr = rq_addr[1]; r1_wdata = rq_wdata[1];
        #2;
        check_cycle();
        cyc++;
    endtask

    task automatic run_txn(input int id, input bit we, input logic [15:0] addr, input logic [255:0] data,
                           output logic [255:0] rd_n, output logic [255:0] rd_w, output logic [255:0] rd_m,
                           output logic er, output int lat);
        bit got;
        got = 0; lat = 0; rd_n = '0; rd_w = '0; rd_m = '0; er = 1'b0;
        rq_we[id] = we; rq_addr[id] = addr; rq_wdata[id] = data; rq_req[id] = 1'b1;
        while (!got && lat < 12) begin
            tick();
            lat++;
            if ((id == 0 ? r0_ack_o[0] : r1_ack_o[0]) === 1'b1) begin
                got = 1; rd_n = rdata_o[0]; rd_w = rdata_o[1]; rd_m = m_rdata[0]; er = err_o[0];
            end
        end
        chk("ack_seen", id, 256'(got), 256'd1);
        rq_req[id] = 1'b0;
    endtask

    // ---------------- directed + random stimulus ----------------
    logic [255:0] rd_n, rd_w, rd_m, lanes;
    logic er;
    int lat, s0, l0, n;
    int ord [4];
    int when [4];

    initial begin
        rst = 1'b1; nxt_rst = 1'b1;
        r0_req = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
        repeat (3) tick();
        chk("reset_rdata", 0, rdata_o[0], '0);
        chk("reset_err", 0, 256'(err_o[0]), '0);
        chk("reset_ack", 0, 256'(r0_ack_o[0] | r1_ack_o[0]), '0);
        chk("reset_fsm", 0, 256'(st_o[0]), '0);
        nxt_rst = 1'b0;
        tick();

        // Single write, then a read-back. A wide value is truncated by the 16-bit instance.
        s0 = sv_cnt[0];
        run_txn(0, 1, 16'd5, 256'h1234, rd_n, rd_w, rd_m, er, lat);
        chk("t1_save_count", 0, 256'(sv_cnt[0] - s0), 256'd1);
        chk("t1_save_addr", 0, 256'(sv_addr[0]), 256'd5);
        chk("t1_in", 0, sv_in[0], 256'h1234);
        chk("t1_err", 0, 256'(er), '0);
        chk("t1_latency", 0, 256'(lat), 256'd3);
        l0 = ld_cnt[0];
        run_txn(1, 0, 16'd5, '0, rd_n, rd_w, rd_m, er, lat);
        chk("t2_load_count", 0, 256'(ld_cnt[0] - l0), 256'd1);
        chk("t2_rdata", 0, rd_n, 256'h1234);
        chk("t2_rdata", 1, rd_w, 256'h1234);
        chk("t2_model", 0, rd_m, 256'h1234);
        run_txn(0, 1, 16'd6, 256'hABCDE, rd_n, rd_w, rd_m, er, lat);
        run_txn(1, 0, 16'd6, '0, rd_n, rd_w, rd_m, er, lat);
        chk("t2_masked", 0, rd_n, 256'hBCDE);
        chk("t2_masked", 1, rd_w, 256'hABCDE);
        chk("t2_model_masked", 0, rd_m, 256'hBCDE);

        // Range boundary: 256 is out of range and 255 is the last valid address.
        s0 = sv_cnt[0];
        run_txn(0, 1, 16'd256, 256'h55, rd_n, rd_w, rd_m, er, lat);
        chk("t4_err_oor", 0, 256'(er), 256'd1);
        chk("t4_no_save", 0, 256'(sv_cnt[0] - s0), '0);
        run_txn(1, 0, 16'd255, '0, rd_n, rd_w, rd_m, er, lat);
        chk("t4_err_last", 0, 256'(er), '0);
        chk("t4_rdata_last", 0, rd_n, '0);

        // Both requesters are held high out of reset, so the grants must alternate.
        nxt_rst = 1'b1;
        rq_we[0] = 1; rq_addr[0] = 16'd20; rq_wdata[0] = rnd256(); rq_req[0] = 1;
        rq_we[1] = 1; rq_addr[1] = 16'd21; rq_wdata[1] = rnd256(); rq_req[1] = 1;
        repeat (2) tick();
        nxt_rst = 1'b0;
        n = 0; ack_overlap = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            tick();
            if (r0_ack_o[0] === 1'b1) begin
                ord[n] = 0; when[n] = cyc; n++; rq_addr[0] += 16'd2; rq_wdata[0] = rnd256();
            end
            if (r1_ack_o[0] === 1'b1 && n < 4) begin
                ord[n] = 1; when[n] = cyc; n++; rq_addr[1] += 16'd2; rq_wdata[1] = rnd256();
            end
        end
        chk("t3_count", 0, 256'(n), 256'd4);
        for (int i = 0; i < 4; i++) chk("t3_order", i, 256'(ord[i]), 256'(i % 2));
        for (int i = 1; i < 4; i++) chk("t3_spacing", i, 256'(when[i] - when[i-1]), 256'd3);
        chk("t3_overlap", 0, 256'(ack_overlap), '0);
        rq_req[0] = 0; rq_req[1] = 0;
        repeat (8) tick();

        // Reset arrives during the RAM cycle of a write. Nothing may commit and no ack may follow.
        run_txn(0, 0, 16'd5, '0, rd_n, rd_w, rd_m, er, lat);
        chk("t5_pre_rdata", 0, rd_n, 256'h1234);
        s0 = sv_cnt[0];
        rq_we[0] = 1; rq_addr[0] = 16'd7; rq_wdata[0] = 256'hBEEF; rq_req[0] = 1;
        tick();
        nxt_rst = 1'b1; rq_req[0] = 0;
        tick();
        chk("t5_save_in_reset", 0, 256'(ram_save_o[0]), '0);
        nxt_rst = 1'b0;
        tick();
        chk("t5_ack", 0, 256'(r0_ack_o[0]), '0);
        chk("t5_rdata", 0, rdata_o[0], '0);
        chk("t5_err", 0, 256'(err_o[0]), '0);
        chk("t5_fsm", 0, 256'(st_o[0]), '0);
        chk("t5_no_commit", 0, 256'(sv_cnt[0] - s0), '0);
        run_txn(1, 0, 16'd7, '0, rd_n, rd_w, rd_m, er, lat);
        chk("t5_read7", 0, rd_n, '0);
        chk("t5_read7", 1, rd_w, '0);

        // Full-width lanes on the 256-bit instance.
        lanes = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
        run_txn(0, 1, 16'd9, lanes, rd_n, rd_w, rd_m, er, lat);
        chk("t6_lanes", 1, sv_in[1], lanes);
        chk("t6_lanes", 0, sv_in[0], 256'hE1F0);
        run_txn(1, 0, 16'd9, '0, rd_n, rd_w, rd_m, er, lat);
        chk("t6_read", 1, rd_w, lanes);
        chk("t6_read", 0, rd_n, 256'hE1F0);

        // Random traffic with occasional resets. Requesters hold their command until acked.
        for (int t = 0; t < 800; t++) begin
            for (int id = 0; id < 2; id++) begin
                if (m_ack[id]) rq_req[id] = 1'($urandom_range(0, 1));
                else if (!rq_req[id] && $urandom_range(0, 3) == 0) rq_req[id] = 1'b1;
                else continue;
                rq_we[id] = 1'($urandom_range(0, 1));
                rq_addr[id] = rnd_addr();
                rq_wdata[id] = rnd256();
            end
            nxt_rst = ($urandom_range(0, 99) == 0);
            tick();
        end
        rq_req[0] = 0; rq_req[1] = 0; nxt_rst = 1'b0;
        repeat (10) tick();
        chk("resp_q_drained", 1, 256'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
